cic_interp_comb_upsampler: RTL and testbench

Front end of the CIC interpolation filter in the sigma-delta DAC path. Accepts low-rate PCM samples over a valid/ready handshake and runs them through `N_STAGES` comb sections (differential delay 1). It then zero-stuffs by `RATE` and drives the high-rate sample stream and enable strobe consumed directly by the cascaded CIC integrator stages. It also owns the rate-change phase counter and reports sample underruns.

---
 rtl/cic_interp_comb_upsampler.sv | 183 ++++++++++++++++++
 tb/tb_cic_interp_comb_upsampler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_comb_upsampler.sv
// cic_interp_comb_upsampler
// Front end of the CIC interpolator in the sigma-delta DAC path.
// - Low-rate PCM samples arrive over a valid/ready handshake.
// - Each sample is passed through N_STAGES comb sections, each with a
//   differential delay of one.
// - The result is held in a single-entry buffer.
// - On each frame-start strobe the buffered value is emitted. The remaining
//   RATE-1 high-rate strobes of the frame carry zero-stuffed samples.
// - A frame start with nothing buffered is an underrun, which is recorded
//   in a sticky flag.
// Optional build macro: CIC_ZOH_EN. When it is defined, the block does a
// zero-order hold: the frame value is repeated in place of the stuffed zeros.
module cic_interp_comb_upsampler #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int N_STAGES = 3,
    parameter int RATE     = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs_ena,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ena,
    output logic             underrun
);

    localparam int              PH_W    = $clog2(RATE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(RATE - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [OUT_W-1:0] pend_q, pend_d;
    logic             pendValid_q, pendValid_d;
    logic             underrun_q, underrun_d;
    logic [OUT_W-1:0] outData_q, outData_d;
    logic             outEna_q;
`ifdef CIC_ZOH_EN
    logic [OUT_W-1:0] hold_q, hold_d;
`endif

    logic [OUT_W-1:0] dly_q [N_STAGES];
    logic [OUT_W-1:0] dlyD [N_STAGES];
    logic [OUT_W-1:0] xExt;
    logic [OUT_W-1:0] combAcc;
    logic             accept;

    assign in_ready = !pendValid_q && !rst;
    assign accept   = in_valid && in_ready;
    assign xExt     = {{(OUT_W - IN_W){in_data[IN_W-1]}}, in_data};

    // Comb chain. Each stage subtracts its delayed input. The input to each
    // stage becomes that stage's next delay value when a sample is accepted.
    always_comb begin
        combAcc = xExt;
        for (int k = 0; k < N_STAGES; k++) begin
            dlyD[k] = combAcc;
            combAcc = combAcc - dly_q[k];
        end
    end

    // Comb delay registers. They advance only on accept, so an underrun
    // leaves the next sample differenced against the last accepted one.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_STAGES; k++) begin
            if (rst) begin
                dly_q[k] <= '0;
            end else if (accept) begin
                dly_q[k] <= dlyD[k];
            end
        end
    end

    // Next state for the buffer, the phase counter and the output sample.
    // An accept can only happen while the buffer is empty, and an emission
    // only while it is full, so the two never update pendValid together.
    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        pend_d      = pend_q;
        pendValid_d = pendValid_q;
        underrun_d  = underrun_q;
        outData_d   = outData_q;
`ifdef CIC_ZOH_EN
        hold_d      = hold_q;
`endif

        if (accept) begin
            pend_d      = combAcc;
            pendValid_d = 1'b1;
        end

        if (hs_ena) begin
            case (state_q)
                ST_IDLE: begin
                    ph_d      = '0;
                    outData_d = '0;
                    if (pendValid_q) begin
                        outData_d   = pend_q;
                        pendValid_d = 1'b0;
                        ph_d        = PH_ONE;
                        state_d     = ST_RUN;
`ifdef CIC_ZOH_EN
                        hold_d      = pend_q;
`endif
                    end
                end
                ST_RUN: begin
                    ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PH_ONE;
                    if (ph_q == '0) begin
                        if (pendValid_q) begin
                            outData_d   = pend_q;
                            pendValid_d = 1'b0;
`ifdef CIC_ZOH_EN
                            hold_d      = pend_q;
`endif
                        end else begin
                            outData_d  = '0;
                            underrun_d = 1'b1;
`ifdef CIC_ZOH_EN
                            hold_d     = '0;
`endif
                        end
                    end else begin
`ifdef CIC_ZOH_EN
                        outData_d = hold_q;
`else
                        outData_d = '0;
`endif
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ph_d    = '0;
                end
            endcase
        end
    end

    // State registers. A synchronous reset drops any pending sample and
    // returns the block to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            pend_q      <= '0;
            pendValid_q <= 1'b0;
            underrun_q  <= 1'b0;
            outData_q   <= '0;
            outEna_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            pend_q      <= pend_d;
            pendValid_q <= pendValid_d;
            underrun_q  <= underrun_d;
            outData_q   <= outData_d;
            outEna_q    <= hs_ena;
        end
    end

`ifdef CIC_ZOH_EN
    // Value of the last frame start, repeated across the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`endif

    assign out_data = outData_q;
    assign out_ena  = outEna_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_cic_interp_comb_upsampler.sv
// Testbench for cic_interp_comb_upsampler.
// Three instances share one stimulus stream:
// - A: 3 combs, 32-bit output.
// - B: 1 comb, 32-bit output.
// - C: 2 combs, 18-bit output, so the wrap cases are visible.
// All three use RATE=4. Every emitted frame value is predicted with the
// binomial form of an N-fold first difference of the accepted-sample
// history, reduced modulo 2^OUT_W.
// Build macro: CIC_ZOH_EN selects the zero-order-hold expectations.
module tb_cic_interp_comb_upsampler;

    localparam int RATE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs_ena;
    logic        in_valid;
    logic [15:0] in_data;

    logic        readyA, readyB, readyC;
    logic [31:0] outA, outB;
    logic [17:0] outC;
    logic        enaA, enaB, enaC;
    logic        underA, underB, underC;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    int          nStg [3] = '{3, 1, 2};
    int          outW [3] = '{32, 32, 18};
    bit          mRun;
    int          mPh;
    bit          mPendValid;
    int          mPendIdx;
    longint      hist [$];
    bit          mUnder;
    bit          mEna;
    logic [63:0] mOut [3];
    logic [63:0] mHold [3];
    longint      feedQ [$];

    always #5 clk = ~clk;

    cic_interp_comb_upsampler #(.IN_W(16), .OUT_W(32), .N_STAGES(3), .RATE(RATE)) dutA (
        .clk(clk), .rst(rst), .hs_ena(hs_ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(readyA), .out_data(outA), .out_ena(enaA), .underrun(underA));

    cic_interp_comb_upsampler #(.IN_W(16), .OUT_W(32), .N_STAGES(1), .RATE(RATE)) dutB (
        .clk(clk), .rst(rst), .hs_ena(hs_ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(readyB), .out_data(outB), .out_ena(enaB), .underrun(underB));

    cic_interp_comb_upsampler #(.IN_W(16), .OUT_W(18), .N_STAGES(2), .RATE(RATE)) dutC (
        .clk(clk), .rst(rst), .hs_ena(hs_ena), .in_data(in_data), .in_valid(in_valid),
        .in_ready(readyC), .out_data(outC), .out_ena(enaC), .underrun(underC));

    function automatic longint binom(input int n, input int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    // N-th difference of the accepted-sample sequence at index idx.
    // Samples before reset count as zero.
    function automatic logic [63:0] combVal(input int n, input int w, input int idx);
        longint      acc = 0;
        logic [63:0] mask;
        for (int j = 0; j <= n; j++) begin
            if (idx - j >= 0) begin
                if (j % 2 == 1) acc = acc - binom(n, j) * hist[idx - j];
                else            acc = acc + binom(n, j) * hist[idx - j];
            end
        end
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return 64'(acc) & mask;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge to the model, using the inputs sampled at that edge.
    task automatic modelEdge(input logic r, input logic hs, input logic v, input logic [15:0] d);
        bit acc;
        acc = v && !mPendValid && !r;
        if (r) begin
            mRun = 0; mPh = 0; mPendValid = 0; mPendIdx = 0; mUnder = 0; mEna = 0;
            hist.delete();
            for (int i = 0; i < 3; i++) begin mOut[i] = '0; mHold[i] = '0; end
            return;
        end
        mEna = hs;
        if (hs) begin
            if (!mRun) begin
                mPh = 0;
                for (int i = 0; i < 3; i++) mOut[i] = '0;
                if (mPendValid) begin
                    for (int i = 0; i < 3; i++) begin
                        mOut[i]  = combVal(nStg[i], outW[i], mPendIdx);
                        mHold[i] = mOut[i];
                    end
                    mPendValid = 0;
                    mPh = 1;
                    mRun = 1;
                end
            end else begin
                if (mPh == 0) begin
                    if (mPendValid) begin
                        for (int i = 0; i < 3; i++) begin
                            mOut[i]  = combVal(nStg[i], outW[i], mPendIdx);
                            mHold[i] = mOut[i];
                        end
                        mPendValid = 0;
                    end else begin
                        mUnder = 1;
                        for (int i = 0; i < 3; i++) begin mOut[i] = '0; mHold[i] = '0; end
                    end
                end else begin
`ifdef CIC_ZOH_EN
                    for (int i = 0; i < 3; i++) mOut[i] = mHold[i];
`else
                    for (int i = 0; i < 3; i++) mOut[i] = '0;
`endif
                end
                mPh = (mPh + 1) % RATE;
            end
        end
        if (acc) begin
            hist.push_back(longint'($signed(d)));
            mPendIdx   = hist.size() - 1;
            mPendValid = 1;
        end
    endtask

    task automatic checkOutput();
        chk("outA",   {32'b0, outA},   mOut[0]);
        chk("outB",   {32'b0, outB},   mOut[1]);
        chk("outC",   {46'b0, outC},   mOut[2]);
        chk("ena",    {61'b0, enaA, enaB, enaC}, {61'b0, mEna, mEna, mEna});
        chk("under",  {61'b0, underA, underB, underC}, {61'b0, mUnder, mUnder, mUnder});
    endtask

    task automatic applyStimulus(input logic r, input logic hs, input logic v, input logic [15:0] d);
        logic expReady;
        rst = r; hs_ena = hs; in_valid = v; in_data = d;
        #1;
        expReady = !mPendValid && !r;
        chk("in_ready", {61'b0, readyA, readyB, readyC}, {61'b0, expReady, expReady, expReady});
        @(posedge clk);
        modelEdge(r, hs, v, d);
        #1;
        checkOutput();
    endtask

    // Offers the queued samples with hs_ena high, popping a sample once it is accepted.
    task automatic feedCycles(input int n);
        bit          v;
        logic [15:0] d;
        bit          willAccept;
        for (int c = 0; c < n; c++) begin
            v = (feedQ.size() > 0);
            d = v ? 16'(feedQ[0]) : 16'h0;
            willAccept = v && !mPendValid;
            applyStimulus(1'b0, 1'b1, v, d);
            if (willAccept) void'(feedQ.pop_front());
        end
    endtask

    task automatic doReset(input int n);
        for (int c = 0; c < n; c++) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        int guard;
        mRun = 0; mPh = 0; mPendValid = 0; mPendIdx = 0; mUnder = 0; mEna = 0;
        for (int i = 0; i < 3; i++) begin mOut[i] = '0; mHold[i] = '0; end

        $display("[TB] reset and idle");
        doReset(3);
        feedCycles(8);

        $display("[TB] repeated 5s");
        doReset(1);
        feedQ = '{5, 5, 5};
        feedCycles(16);

        $display("[TB] impulse and step");
        doReset(1);
        feedQ = '{1, 0, 0, 0, 0};
        feedCycles(24);
        doReset(1);
        feedQ = '{1, 1, 1, 1, 1};
        feedCycles(24);

        $display("[TB] wrap");
        doReset(1);
        feedQ = '{-32768, 32767, -32768, 32767};
        feedCycles(20);

        $display("[TB] underrun");
        doReset(1);
        feedQ = '{7, -3};
        feedCycles(8);
        feedCycles(6);
        feedQ = '{11, 2};
        feedCycles(12);

        $display("[TB] mid-frame reset");
        doReset(1);
        feedQ = '{100, 200};
        guard = 0;
        while (!(mRun && mPh == 2 && mPendValid) && guard < 40) begin
            feedCycles(1);
            guard++;
        end
        chk("reach_ph2", {63'b0, (guard < 40)}, 64'd1);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'd5);
        feedQ = '{-9, 4};
        feedCycles(12);

        $display("[TB] random");
        doReset(1);
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                          1'($urandom_range(0, 1)),
                          16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
